// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: grants one of five approaches (Mid, L, R, T, D) at a
// time through GREEN -> YELLOW -> ALLRED, with density-scaled green, emergency
// preemption/hold and a starvation guard.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   act[4:0]        - per-approach request valid (bit0 = Mid ... bit4 = D)
//   density[19:0]   - packed 4-bit densities, approach i at [4i+3:4i]
//   emerg[4:0]      - per-approach emergency-vehicle flag
//   green, yellow   - one-hot signal heads (registered)
//   phase           - 0 IDLE, 1 GREEN, 2 YELLOW, 3 ALLRED (registered)
//   cur_app         - last/current granted approach (registered)
//   timer           - remaining cycles in the timed state minus 1 (registered)
//   grant           - pulse in the first GREEN cycle (registered)
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned GREEN_PER_CAR = 3,
  parameter int unsigned MAX_GREEN     = 40,
  parameter int unsigned YELLOW_T      = 3,
  parameter int unsigned ALLRED_T      = 1,
  parameter int unsigned STARVE_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  act,
  input  logic [19:0] density,
  input  logic [4:0]  emerg,
  output logic [4:0]  green,
  output logic [4:0]  yellow,
  output logic [1:0]  phase,
  output logic [2:0]  cur_app,
  output logic [5:0]  timer,
  output logic        grant
);

  localparam int unsigned NAPP = 5;
  localparam int unsigned DW   = 4;
  localparam int unsigned TW   = 6;
  localparam int unsigned CW   = 3;
  localparam int unsigned SW   = 3;
  localparam int unsigned DURW = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_d;
  logic [CW-1:0]   cur_d;
  logic [NAPP-1:0] green_d, yellow_d;
  logic            grant_d;
  logic [SW-1:0]   starve_q [NAPP];
  logic [SW-1:0]   starve_d [NAPP];

  logic [DW-1:0]   dens [NAPP];
  logic [NAPP-1:0] elig;
  logic [NAPP-1:0] cur_mask;
  logic            preempt;

  logic            found_e, found_s, found_d;
  logic [CW-1:0]   pick_e, pick_s, pick_d, idx, sel;
  logic [DW-1:0]   best;
  logic [DURW-1:0] dur_raw, dur;

  // Round-robin search position k, starting just after base.
  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + 32'd1 + k;
    return CW'(s % NAPP);
  endfunction

  // Unpack densities and derive eligibility.
  always_comb begin
    for (int i = 0; i < NAPP; i++) begin
      dens[i] = density[DW*i +: DW];
      elig[i] = act[i] && ((dens[i] != '0) || emerg[i]);
    end
  end

  assign cur_mask = NAPP'(1) << cur_app;
  // Another eligible approach raised emergency (eligible-with-emerg == act & emerg).
  assign preempt  = |(act & emerg & ~cur_mask);

  // Selection: emergency first, then starved, then highest density (first wins ties).
  always_comb begin
    found_e = 1'b0;
    found_s = 1'b0;
    found_d = 1'b0;
    pick_e  = '0;
    pick_s  = '0;
    pick_d  = '0;
    best    = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NAPP; k++) begin
      idx = rr_idx(cur_app, k);
      if (elig[idx]) begin
        if (emerg[idx] && !found_e) begin
          found_e = 1'b1;
          pick_e  = idx;
        end
        if ((starve_q[idx] >= SW'(STARVE_LIMIT)) && !found_s) begin
          found_s = 1'b1;
          pick_s  = idx;
        end
        if (!found_d || (dens[idx] > best)) begin
          found_d = 1'b1;
          pick_d  = idx;
          best    = dens[idx];
        end
      end
    end
    sel = found_e ? pick_e : (found_s ? pick_s : pick_d);
  end

  // Green duration, computed wide then saturated; emergency grants get the cap.
  always_comb begin
    dur_raw = DURW'(MIN_GREEN) + DURW'(GREEN_PER_CAR) * DURW'(dens[sel]);
    if (found_e || (dur_raw > DURW'(MAX_GREEN))) dur = DURW'(MAX_GREEN);
    else                                          dur = dur_raw;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer;
    cur_d    = cur_app;
    green_d  = '0;
    yellow_d = '0;
    grant_d  = 1'b0;
    for (int i = 0; i < NAPP; i++) starve_d[i] = starve_q[i];

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (|elig) begin
          state_d = S_GREEN;
          timer_d = TW'(dur - DURW'(1));
          cur_d   = sel;
          green_d = NAPP'(1) << sel;
          grant_d = 1'b1;
          for (int i = 0; i < NAPP; i++) begin
            if (CW'(i) == sel)                      starve_d[i] = '0;
            else if (elig[i] && (starve_q[i] != '1)) starve_d[i] = starve_q[i] + SW'(1);
          end
        end
      end
      S_GREEN: begin
        green_d = cur_mask;
        if (emerg[cur_app]) begin
          // Emergency on the served approach: hold the timer.
          timer_d = timer;
        end else if (preempt || (timer == '0)) begin
          state_d  = S_YELLOW;
          timer_d  = TW'(YELLOW_T - 1);
          green_d  = '0;
          yellow_d = cur_mask;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      S_YELLOW: begin
        yellow_d = cur_mask;
        if (timer == '0) begin
          state_d  = S_ALLRED;
          timer_d  = TW'(ALLRED_T - 1);
          yellow_d = '0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      S_ALLRED: begin
        if (timer == '0) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer   <= '0;
      cur_app <= CW'(4);
      green   <= '0;
      yellow  <= '0;
      grant   <= 1'b0;
      for (int i = 0; i < NAPP; i++) starve_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer   <= timer_d;
      cur_app <= cur_d;
      green   <= green_d;
      yellow  <= yellow_d;
      grant   <= grant_d;
      for (int i = 0; i < NAPP; i++) starve_q[i] <= starve_d[i];
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed stimulus, an abstract cycle model of the
// junction scheduler compared every cycle, plus hand-computed literal checks.
module tb_traffic_phase_scheduler;

  localparam int MIN_GREEN     = 4;
  localparam int GREEN_PER_CAR = 3;
  localparam int MAX_GREEN     = 40;
  localparam int YELLOW_T      = 3;
  localparam int ALLRED_T      = 1;
  localparam int STARVE_LIMIT  = 3;
  localparam int LIM           = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  act = '0;
  logic [19:0] density = '0;
  logic [4:0]  emerg = '0;
  logic [4:0]  green, yellow;
  logic [1:0]  phase;
  logic [2:0]  cur_app;
  logic [5:0]  timer;
  logic        grant;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  traffic_phase_scheduler #(
    .MIN_GREEN(MIN_GREEN), .GREEN_PER_CAR(GREEN_PER_CAR), .MAX_GREEN(MAX_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .act(act), .density(density), .emerg(emerg),
    .green(green), .yellow(yellow), .phase(phase), .cur_app(cur_app),
    .timer(timer), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout waiting t=%0t", name, $time);
  endtask

  // ---------------- abstract model ----------------
  // m_phase: 0 idle, 1 green, 2 yellow, 3 allred; m_left: cycles still to show.
  int m_phase = 0;
  int m_left  = 0;
  int m_cur   = 4;
  int m_starve [5];
  bit m_grant = 1'b0;

  function automatic int dens_of(input logic [19:0] d, input int i);
    logic [19:0] t;
    t = d >> (4 * i);
    return int'(t[3:0]);
  endfunction

  function automatic bit is_elig(input int i);
    return act[i] && ((dens_of(density, i) != 0) || emerg[i]);
  endfunction

  // Build the eligible list in search order, then apply the priority rules.
  function automatic int model_pick(output bit is_em);
    int order[$];
    int res;
    bit done;
    is_em = 1'b0;
    res = -1;
    done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (is_elig((m_cur + 1 + k) % 5)) order.push_back((m_cur + 1 + k) % 5);
    end
    if (order.size() != 0) begin
      foreach (order[n]) if (!done && emerg[order[n]]) begin
        res = order[n]; is_em = 1'b1; done = 1'b1;
      end
      foreach (order[n]) if (!done && m_starve[order[n]] >= STARVE_LIMIT) begin
        res = order[n]; done = 1'b1;
      end
      if (!done) begin
        res = order[0];
        foreach (order[n]) if (dens_of(density, order[n]) > dens_of(density, res)) res = order[n];
      end
    end
    return res;
  endfunction

  always @(posedge clk) begin : model
    int sel;
    int d;
    bit em;
    bit pre;
    if (rst) begin
      m_phase = 0; m_left = 0; m_cur = 4; m_grant = 1'b0;
      for (int i = 0; i < 5; i++) m_starve[i] = 0;
    end else begin
      m_grant = 1'b0;
      case (m_phase)
        0: begin
          sel = model_pick(em);
          if (sel >= 0) begin
            for (int i = 0; i < 5; i++) begin
              if (i == sel) m_starve[i] = 0;
              else if (is_elig(i) && m_starve[i] < 7) m_starve[i]++;
            end
            d = MIN_GREEN + GREEN_PER_CAR * dens_of(density, sel);
            if (em || d > MAX_GREEN) d = MAX_GREEN;
            m_cur = sel; m_phase = 1; m_left = d; m_grant = 1'b1;
          end
        end
        1: begin
          pre = 1'b0;
          for (int j = 0; j < 5; j++) if (j != m_cur && act[j] && emerg[j]) pre = 1'b1;
          if (emerg[m_cur]) begin
            m_left = m_left;
          end else if (pre || m_left == 1) begin
            m_phase = 2; m_left = YELLOW_T;
          end else m_left--;
        end
        2: if (m_left == 1) begin m_phase = 3; m_left = ALLRED_T; end else m_left--;
        default: if (m_left == 1) begin m_phase = 0; m_left = 0; end else m_left--;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic [4:0] eg, ey;
    int et;
    eg = (m_phase == 1) ? 5'(1 << m_cur) : 5'b0;
    ey = (m_phase == 2) ? 5'(1 << m_cur) : 5'b0;
    et = (m_phase == 0) ? 0 : m_left - 1;
    if (chk_en) begin
      check("m_green",   32'(green),   32'(eg));
      check("m_yellow",  32'(yellow),  32'(ey));
      check("m_phase",   32'(phase),   32'(m_phase));
      check("m_cur_app", 32'(cur_app), 32'(m_cur));
      check("m_timer",   32'(timer),   32'(et));
      check("m_grant",   32'(grant),   32'(m_grant));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (grant !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout_fail(name);
  endtask

  task automatic wait_timer(input int v, input string name);
    int n;
    n = 0;
    while (timer !== 6'(v) && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) timeout_fail(name);
  endtask

  // kind 0: green==mask, 1: yellow==mask, 2: all-red phase.
  task automatic run_len(input int kind, input logic [4:0] mask, output int n);
    n = 0;
    while (n < LIM &&
           ((kind == 0 && phase == 2'd1 && green === mask) ||
            (kind == 1 && phase == 2'd2 && yellow === mask) ||
            (kind == 2 && phase == 2'd3 && green === 5'b0 && yellow === 5'b0))) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic [4:0] a, input logic [19:0] d, input logic [4:0] e);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    act = a; density = d; emerg = e;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    int n;
    int g [5];
    // Reset with active inputs.
    rst = 1'b1; act = 5'b11111; density = 20'hFFFFF; emerg = 5'b00100;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_green", 32'(green), 32'd0);
    check("rst_cur",   32'(cur_app), 32'd4);
    check("rst_timer", 32'(timer), 32'd0);

    // Release: Mid density 3 -> 13 green, 3 yellow, 1 all-red.
    act = 5'b00001; density = 20'h00003; emerg = 5'b0; rst = 1'b0;
    wait_grant("rst_grant");
    check("rst_gcur", 32'(cur_app), 32'd0);
    run_len(0, 5'b00001, n); check("rst_green_len", 32'(n), 32'd13);
    run_len(1, 5'b00001, n); check("rst_yel_len",   32'(n), 32'd3);
    run_len(2, 5'b00000, n); check("rst_ar_len",    32'(n), 32'd1);

    // Density pick: L (9) first with 31 cycles, then T.
    do_reset(5'b11111, 20'h19592, 5'b0);
    wait_grant("dp_grant1");
    check("dp_first", 32'(cur_app), 32'd1);
    run_len(0, 5'b00010, n); check("dp_green_len", 32'(n), 32'd31);
    wait_grant("dp_grant2");
    check("dp_second", 32'(cur_app), 32'd3);

    // Saturation: R density 15 -> capped at 40.
    do_reset(5'b00100, 20'h00F00, 5'b0);
    wait_grant("sat_grant");
    run_len(0, 5'b00100, n); check("sat_len", 32'(n), 32'd40);

    // Preemption by D during a Mid green, then emergency hold.
    do_reset(5'b00001, 20'h00009, 5'b0);
    wait_grant("pre_grant");
    wait_timer(20, "pre_t20");
    emerg = 5'b10000; act = 5'b10001;
    @(negedge clk);
    check("pre_yellow", 32'(yellow), 32'd1);
    check("pre_green0", 32'(green),  32'd0);
    wait_grant("pre_dgrant");
    check("pre_dcur", 32'(cur_app), 32'd4);
    repeat (4) @(negedge clk);
    check("pre_hold", 32'(timer), 32'd39);
    emerg = 5'b0;
    run_len(0, 5'b10000, n); check("pre_dlen", 32'(n), 32'd40);

    // Starvation: L three times, Mid forced on the 4th, then L again.
    do_reset(5'b00011, 20'h000F1, 5'b0);
    for (int k = 0; k < 5; k++) begin
      wait_grant("st_grant");
      g[k] = int'(cur_app);
      @(negedge clk);
    end
    check("st_g1", 32'(g[0]), 32'd1);
    check("st_g2", 32'(g[1]), 32'd1);
    check("st_g3", 32'(g[2]), 32'd1);
    check("st_g4", 32'(g[3]), 32'd0);
    check("st_g5", 32'(g[4]), 32'd1);

    // Reset mid-green: green drops at once, no yellow.
    do_reset(5'b00001, 20'h00009, 5'b0);
    wait_grant("rmg_grant");
    wait_timer(5, "rmg_t5");
    rst = 1'b1;
    @(negedge clk);
    check("rmg_green",  32'(green),  32'd0);
    check("rmg_yellow", 32'(yellow), 32'd0);
    check("rmg_phase",  32'(phase),  32'd0);
    @(negedge clk);
    check("rmg_yellow2", 32'(yellow), 32'd0);
    act = 5'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stay", 32'(phase), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
